// File: rtl/nibble_serial_tx.sv
// ============================================================================
// Module      : nibble_serial_tx
// Description : Transmit end of the 4-bit nibble link. Accepts one nibble per
//               valid/ready handshake and sends it as a UART-style frame:
//               start bit, data LSB first, optional even parity, stop bit.
//               Each bit is held for BIT_CYCLES clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 10,
  parameter int PARITY_EN  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CYC_W = $clog2(BIT_CYCLES + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CYC_W-1:0] c_CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [CYC_W-1:0]    r_cyc_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic                r_tx;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [CYC_W-1:0]    w_cyc_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [DATA_W-1:0]   w_shifted;
  logic                w_parity_nxt;
  logic                w_tx_nxt;
  logic                w_ready_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_bit_end;

  // State and all datapath registers; reset forces the line idle and aborts any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cyc_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_tx       <= w_tx_nxt;
      r_in_ready <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; tx only changes at bit boundaries
  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_nxt     = r_tx;
    w_ready_nxt  = r_in_ready;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_shifted    = r_shift >> 1;
    w_bit_end    = (r_cyc_cnt == c_CYC_LAST);

    if (r_state != S_IDLE) begin
      w_cyc_nxt = w_bit_end ? '0 : r_cyc_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
        w_cyc_nxt   = '0;
        w_bit_nxt   = '0;
        // in_ready is a register, so the handshake has no combinational path
        if (in_valid && r_in_ready) begin
          w_shift_nxt  = in_data;
          w_parity_nxt = ^in_data;
          w_state_nxt  = S_START;
          w_ready_nxt  = 1'b0;
          w_busy_nxt   = 1'b1;
          w_tx_nxt     = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_BIT_LAST) begin
            if (PARITY_EN != 0) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_shift_nxt = w_shifted;
            w_tx_nxt    = w_shifted[0];
            w_bit_nxt   = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign in_ready = r_in_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_tx.sv
// ============================================================================
// Module      : tb_nibble_serial_tx
// Description : Self-checking bench for nibble_serial_tx. Three instances:
//               defaults, parity enabled, and single-cycle bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rst2;
  logic [3:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       bsy0, bsy1, bsy2;
  logic       dn0, dn1, dn2;

  int total = 0;
  int bad   = 0;

  nibble_serial_tx #(.DATA_W(4), .BIT_CYCLES(10), .PARITY_EN(0)) u_d0 (
    .clk(clk), .rst_n(rst0), .in_data(d0), .in_valid(v0),
    .in_ready(rdy0), .tx(tx0), .busy(bsy0), .done(dn0));

  nibble_serial_tx #(.DATA_W(4), .BIT_CYCLES(10), .PARITY_EN(1)) u_d1 (
    .clk(clk), .rst_n(rst1), .in_data(d1), .in_valid(v1),
    .in_ready(rdy1), .tx(tx1), .busy(bsy1), .done(dn1));

  nibble_serial_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_EN(0)) u_d2 (
    .clk(clk), .rst_n(rst2), .in_data(d2), .in_valid(v2),
    .in_ready(rdy2), .tx(tx2), .busy(bsy2), .done(dn2));

  typedef struct {
    int         cfg;
    logic [3:0] data;
    logic [7:0] bits;   // bits[i] = i-th bit on the line, start bit first
    int         nbits;
    int         bc;
  } vec_t;

  vec_t vecs[7];

  // {tx, busy, done, in_ready} of the selected instance
  function automatic logic [3:0] f_obs(int c);
    case (c)
      0:       return {tx0, bsy0, dn0, rdy0};
      1:       return {tx1, bsy1, dn1, rdy1};
      default: return {tx2, bsy2, dn2, rdy2};
    endcase
  endfunction

  task automatic set_in(int c, logic [3:0] d, logic v);
    case (c)
      0:       begin d0 = d; v0 = v; end
      1:       begin d1 = d; v1 = v; end
      default: begin d2 = d; v2 = v; end
    endcase
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Ends on a negedge where in_ready is high
  task automatic wait_ready(int c);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (f_obs(c)[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", 32'(ok), 32'd1);
  endtask

  task automatic run_frame(vec_t v);
    logic [3:0] rebuilt;
    int         len;
    rebuilt = 4'h0;
    len     = v.nbits * v.bc;
    wait_ready(v.cfg);
    set_in(v.cfg, v.data, 1'b1);
    @(posedge clk);
    #1;
    set_in(v.cfg, ~v.data, 1'b0);
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("frame_bit", 32'(f_obs(v.cfg)), {28'd0, v.bits[k / v.bc], 3'b100});
      if ((k % v.bc) == (v.bc / 2) && (k / v.bc) >= 1 && (k / v.bc) <= 4)
        rebuilt[(k / v.bc) - 1] = f_obs(v.cfg)[3];
    end
    @(posedge clk);
    #1;
    chk("frame_end", 32'(f_obs(v.cfg)), 32'b1011);
    @(posedge clk);
    #1;
    chk("done_clear", 32'(f_obs(v.cfg)), 32'b1001);
    chk("rebuilt", 32'(rebuilt), 32'(v.data));
  endtask

  initial begin
    logic [13:0] bb_tx;
    logic [3:0]  got;
    logic        seen;

    vecs[0] = '{cfg: 0, data: 4'hA, bits: 8'b00110100, nbits: 6, bc: 10};
    vecs[1] = '{cfg: 0, data: 4'h3, bits: 8'b00100110, nbits: 6, bc: 10};
    vecs[2] = '{cfg: 1, data: 4'h7, bits: 8'b01101110, nbits: 7, bc: 10};
    vecs[3] = '{cfg: 1, data: 4'hA, bits: 8'b01010100, nbits: 7, bc: 10};
    vecs[4] = '{cfg: 1, data: 4'h0, bits: 8'b01000000, nbits: 7, bc: 10};
    vecs[5] = '{cfg: 1, data: 4'hF, bits: 8'b01011110, nbits: 7, bc: 10};
    vecs[6] = '{cfg: 2, data: 4'hC, bits: 8'b00111000, nbits: 6, bc: 1};

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

    // Reset: outputs idle, in_ready low, then high one edge after release
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) chk("reset_state", 32'(f_obs(c)), 32'b1000);
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) chk("pre_edge", 32'(f_obs(c)), 32'b1000);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) chk("ready_after_rst", 32'(f_obs(c)), 32'b1001);

    // Table-driven frames
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Back-to-back with single-cycle bits: 3 then C, one idle cycle between
    bb_tx = 14'b11110001100110;
    wait_ready(2);
    set_in(2, 4'h3, 1'b1);
    @(posedge clk);
    #1;
    set_in(2, 4'hC, 1'b1);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      got = f_obs(2);
      chk("b2b", {29'd0, got[3:1]},
          {29'd0, bb_tx[k], (k != 6 && k != 13), (k == 6 || k == 13)});
      if (k == 7) set_in(2, 4'h0, 1'b0);
    end

    // Input changes while busy are ignored; accepted only during done's cycle
    wait_ready(0);
    set_in(0, 4'h5, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, 4'h0, 1'b0);
    got = 4'h0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) set_in(0, 4'hF, 1'b1);
      if ((k % 10) == 5 && k >= 15 && k <= 45) got[(k / 10) - 1] = tx0;
      if (k < 60) chk("busy_hold", {30'd0, rdy0, bsy0}, 32'b01);
    end
    chk("busy_done", 32'(f_obs(0)), 32'b1011);
    chk("busy_bits", 32'(got), 32'h5);
    @(posedge clk);
    #1;
    chk("busy_reaccept", 32'(f_obs(0)), 32'b0100);
    set_in(0, 4'h0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dn0) seen = 1'b1;
    end
    chk("second_done", 32'(seen), 32'd1);

    // Asynchronous reset mid-frame aborts with no done pulse
    wait_ready(0);
    set_in(0, 4'h9, 1'b1);
    @(posedge clk);
    #1;
    set_in(0, 4'h0, 1'b0);
    repeat (24) @(posedge clk);
    #3;
    chk("pre_abort_tx", 32'(tx0), 32'd0);
    rst0 = 1'b0;
    #1;
    chk("abort_state", 32'(f_obs(0)), 32'b1000);
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      chk("post_abort", {29'd0, f_obs(0)[3:1]}, 32'b100);
    end
    chk("post_abort_ready", 32'(rdy0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
